// File: rtl/washer_pkg.sv
// Shared types for the wash-cycle sequencer: states, fault codes and the
// per-state actuator vectors (valve, heater, motor, pump, door lock).
package washer_pkg;

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_FILL        = 4'd1,
      S_HEAT        = 4'd2,
      S_WASH        = 4'd3,
      S_DRAIN       = 4'd4,
      S_RINSE_FILL  = 4'd5,
      S_RINSE       = 4'd6,
      S_ABORT_DRAIN = 4'd7,
      S_FAULT       = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE       = 3'd0,
      ERR_FILL_TO    = 3'd1,
      ERR_HEAT_TO    = 3'd2,
      ERR_DRAIN_TO   = 3'd3,
      ERR_WATER_LOST = 3'd4
   } err_t;

   typedef struct packed {
      logic valve;
      logic heater;
      logic motor;
      logic pump;
      logic lock;
   } act_t;

   localparam act_t ACT_IDLE  = 5'b00000;
   localparam act_t ACT_FILL  = 5'b10001;
   localparam act_t ACT_HEAT  = 5'b01001;
   localparam act_t ACT_SPIN  = 5'b00101;
   localparam act_t ACT_DRAIN = 5'b00011;
   localparam act_t ACT_FAULT = 5'b00001;

   // Moore decode: actuators depend only on the current state.
   function automatic act_t act_decode(input state_t s);
      act_t a;
      case (s)
         S_FILL, S_RINSE_FILL:   a = ACT_FILL;
         S_HEAT:                 a = ACT_HEAT;
         S_WASH, S_RINSE:        a = ACT_SPIN;
         S_DRAIN, S_ABORT_DRAIN: a = ACT_DRAIN;
         S_FAULT:                a = ACT_FAULT;
         default:                a = ACT_IDLE;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/wash_cycle_sequencer_tick_timer.sv
// Tick prescaler plus saturating phase counter; the counter clears whenever
// the sequencer changes state.
module wash_tick_timer #(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned TICK_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   output logic              tick_c,
   output logic [TICK_W-1:0] count_o
);

   localparam int unsigned       PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] CNT_MAX = '1;

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [TICK_W-1:0] cnt_q, cnt_d;

   assign tick_c  = (pre_q == PRE_MAX);
   assign count_o = cnt_q;

   always_comb begin
      pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + TICK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program controller: fill, heat, wash, drain, N rinses,
// with per-phase timeouts, user abort and a latched fault code.
module wash_cycle_sequencer
   import washer_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 1000,
   parameter int unsigned TICK_W      = 16,
   parameter int unsigned FILL_TO     = 200,
   parameter int unsigned HEAT_TO     = 400,
   parameter int unsigned DRAIN_TO    = 100,
   parameter int unsigned WASH_TICKS  = 600,
   parameter int unsigned RINSE_TICKS = 150
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       clr_err,
   input  logic [1:0] rinses,
   input  logic       full,
   input  logic       hot,
   input  logic       empty,
   output logic       heater,
   output logic       valve,
   output logic       motor,
   output logic       pump,
   output logic       door_lock,
   output logic       busy,
   output logic       done,
   output logic [2:0] err_code
);

   localparam logic [TICK_W-1:0] FILL_LIM  = TICK_W'(FILL_TO);
   localparam logic [TICK_W-1:0] HEAT_LIM  = TICK_W'(HEAT_TO);
   localparam logic [TICK_W-1:0] DRAIN_LIM = TICK_W'(DRAIN_TO);
   localparam logic [TICK_W-1:0] WASH_LIM  = TICK_W'(WASH_TICKS);
   localparam logic [TICK_W-1:0] RINSE_LIM = TICK_W'(RINSE_TICKS);

   state_t            state_q, state_d;
   err_t              err_q, err_d;
   logic [1:0]        rcnt_q, rcnt_d;
   logic              done_q, done_d;
   logic              fault_hit;
   err_t              fault_code;
   logic              timer_clr;
   logic              tick_unused;
   logic [TICK_W-1:0] timer;
   act_t              act;

   assign timer_clr = (state_d != state_q);

   wash_tick_timer #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (timer_clr),
      .tick_c  (tick_unused),
      .count_o (timer)
   );

   // Next state: the sensor condition is tested before its timeout, and a
   // fault raised this cycle outranks a concurrent abort.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      rcnt_d     = rcnt_q;
      fault_hit  = 1'b0;
      fault_code = ERR_NONE;
      case (state_q)
         S_IDLE: begin
            if (start && !abort && (err_q == ERR_NONE)) begin
               state_d = S_FILL;
               rcnt_d  = rinses;
            end
         end
         S_FILL, S_RINSE_FILL: begin
            if (full) begin
               state_d = (state_q == S_FILL) ? S_HEAT : S_RINSE;
            end else if (timer == FILL_LIM) begin
               fault_hit  = 1'b1;
               fault_code = ERR_FILL_TO;
            end
         end
         S_HEAT: begin
            if (hot) begin
               state_d = S_WASH;
            end else if (!full) begin
               fault_hit  = 1'b1;
               fault_code = ERR_WATER_LOST;
            end else if (timer == HEAT_LIM) begin
               fault_hit  = 1'b1;
               fault_code = ERR_HEAT_TO;
            end
         end
         S_WASH, S_RINSE: begin
            if (timer == ((state_q == S_WASH) ? WASH_LIM : RINSE_LIM)) begin
               state_d = S_DRAIN;
            end else if (!full) begin
               fault_hit  = 1'b1;
               fault_code = ERR_WATER_LOST;
            end
         end
         S_DRAIN, S_ABORT_DRAIN: begin
            if (empty) begin
               if ((state_q == S_DRAIN) && (rcnt_q != 2'd0)) begin
                  state_d = S_RINSE_FILL;
                  rcnt_d  = rcnt_q - 2'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (timer == DRAIN_LIM) begin
               fault_hit  = 1'b1;
               fault_code = ERR_DRAIN_TO;
            end
         end
         S_FAULT: begin
            if (clr_err && empty) begin
               state_d = S_IDLE;
               err_d   = ERR_NONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fault_hit) begin
         state_d = S_FAULT;
         err_d   = fault_code;
      end else if (abort && (state_q inside {S_FILL, S_HEAT, S_WASH, S_DRAIN,
                                             S_RINSE_FILL, S_RINSE})) begin
         state_d = S_ABORT_DRAIN;
         rcnt_d  = rcnt_q;
      end

      done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= ERR_NONE;
         rcnt_q  <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rcnt_q  <= rcnt_d;
         done_q  <= done_d;
      end
   end

   assign act       = act_decode(state_q);
   assign valve     = act.valve;
   assign heater    = act.heater;
   assign motor     = act.motor;
   assign pump      = act.pump;
   assign door_lock = act.lock;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err_code  = err_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Bench for wash_cycle_sequencer: directed vector table, corner sequences and
// randomized sensor traffic against a cycle-level behavioural model.
module tb_wash_cycle_sequencer;

   localparam int TDIV = 4;
   localparam int TW   = 16;
   localparam int FTO  = 5;
   localparam int HTO  = 5;
   localparam int DTO  = 5;
   localparam int WT   = 3;
   localparam int RT   = 2;
   localparam int MAXT = (1 << TW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, abort = 1'b0, clr_err = 1'b0;
   logic [1:0] rinses = 2'd0;
   logic       full = 1'b0, hot = 1'b0, empty = 1'b0;
   logic       heater, valve, motor, pump, door_lock, busy, done;
   logic [2:0] err_code;

   always #5 clk = ~clk;

   wash_cycle_sequencer #(
      .TICK_DIV(TDIV), .TICK_W(TW), .FILL_TO(FTO), .HEAT_TO(HTO),
      .DRAIN_TO(DTO), .WASH_TICKS(WT), .RINSE_TICKS(RT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .clr_err(clr_err),
      .rinses(rinses), .full(full), .hot(hot), .empty(empty),
      .heater(heater), .valve(valve), .motor(motor), .pump(pump),
      .door_lock(door_lock), .busy(busy), .done(done), .err_code(err_code)
   );

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   // Behavioural model: program phase, ticks spent in it, rinses left.
   typedef enum int {M_IDLE, M_FILL, M_HEAT, M_WASH, M_DRAIN, M_RFILL, M_RINSE, M_ABD, M_FAULT} mph_e;
   mph_e     m_ph;
   int       m_el, m_rc, m_edges;
   bit       m_done;
   bit [2:0] m_err;

   function automatic bit [4:0] m_act(input mph_e p);
      case (p)
         M_FILL, M_RFILL: return 5'b10001;
         M_HEAT:          return 5'b01001;
         M_WASH, M_RINSE: return 5'b00101;
         M_DRAIN, M_ABD:  return 5'b00011;
         M_FAULT:         return 5'b00001;
         default:         return 5'b00000;
      endcase
   endfunction

   function automatic bit [4:0] dut_act();
      return {valve, heater, motor, pump, door_lock};
   endfunction

   task automatic model_reset();
      m_ph = M_IDLE; m_el = 0; m_rc = 0; m_edges = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit       tick;
      mph_e     nx;
      bit [2:0] code;
      int       nrc;
      if (rst) begin
         model_reset();
         return;
      end
      tick = (m_edges % TDIV) == TDIV - 1;
      m_edges++;
      nx = m_ph; code = 0; nrc = m_rc;
      case (m_ph)
         M_IDLE:  if (start && !abort && m_err == 0) begin nx = M_FILL; nrc = int'(rinses); end
         M_FILL:  if (full) nx = M_HEAT; else if (m_el == FTO) code = 1;
         M_RFILL: if (full) nx = M_RINSE; else if (m_el == FTO) code = 1;
         M_HEAT:  if (hot) nx = M_WASH; else if (!full) code = 4; else if (m_el == HTO) code = 2;
         M_WASH:  if (m_el == WT) nx = M_DRAIN; else if (!full) code = 4;
         M_RINSE: if (m_el == RT) nx = M_DRAIN; else if (!full) code = 4;
         M_DRAIN: if (empty) begin
                     if (m_rc > 0) begin nx = M_RFILL; nrc = m_rc - 1; end
                     else nx = M_IDLE;
                  end else if (m_el == DTO) code = 3;
         M_ABD:   if (empty) nx = M_IDLE; else if (m_el == DTO) code = 3;
         M_FAULT: if (clr_err && empty) nx = M_IDLE;
         default: nx = M_IDLE;
      endcase
      if (code != 0) nx = M_FAULT;
      else if (abort && m_ph != M_IDLE && m_ph != M_ABD && m_ph != M_FAULT) begin
         nx = M_ABD; nrc = m_rc;
      end
      m_done = (m_ph == M_DRAIN) && (nx == M_IDLE);
      if (code != 0) m_err = code;
      else if (m_ph == M_FAULT && nx == M_IDLE) m_err = 0;
      if (nx != m_ph) m_el = 0;
      else if (tick) m_el = (m_el >= MAXT) ? MAXT : m_el + 1;
      m_ph = nx; m_rc = nrc;
   endtask

   task automatic check_model();
      checks++;
      if ({dut_act(), busy, done, err_code} !== {m_act(m_ph), m_ph != M_IDLE, m_done, m_err}) begin
         errors++;
         $display("FAIL model t=%0t got act=%b busy=%b done=%b err=%0d exp act=%b busy=%b done=%b err=%0d",
                  $time, dut_act(), busy, done, err_code, m_act(m_ph), m_ph != M_IDLE, m_done, m_err);
      end
   endtask

   // One clock: model follows the edge, outputs are compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
      if (done === 1'b1) done_seen++;
   endtask

   typedef struct {
      string    nm;
      bit       st, ab, cl, fu, ho, em;
      bit [1:0] rn;
      bit [4:0] act;
      bit [2:0] err;
      bit       hold;
      int       n;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input string nm, input bit [5:0] in, input bit [1:0] rn,
                               input bit [4:0] act, input bit [2:0] err, input bit hold, input int n);
      vec_t v;
      v.nm = nm;
      {v.st, v.ab, v.cl, v.fu, v.ho, v.em} = in;
      v.rn = rn; v.act = act; v.err = err; v.hold = hold; v.n = n;
      return v;
   endfunction

   function automatic bit dut_is(input bit [4:0] act, input bit [2:0] err);
      return (dut_act() === act) && (busy === (act != 5'b0)) && (err_code === err);
   endfunction

   task automatic run_vec(input vec_t v);
      bit ok;
      {start, abort, clr_err, full, hot, empty} = {v.st, v.ab, v.cl, v.fu, v.ho, v.em};
      rinses = v.rn;
      if (v.hold) begin
         for (int c = 0; c < v.n; c++) begin
            cycle();
            checks++;
            if (!dut_is(v.act, v.err)) begin
               errors++;
               $display("FAIL %s cyc%0d got act=%b err=%0d exp act=%b err=%0d",
                        v.nm, c, dut_act(), err_code, v.act, v.err);
            end
         end
      end else begin
         ok = 0;
         for (int c = 0; c < v.n && !ok; c++) begin
            cycle();
            ok = dut_is(v.act, v.err);
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL %s within %0d got act=%b err=%0d exp act=%b err=%0d",
                     v.nm, v.n, dut_act(), err_code, v.act, v.err);
         end
      end
   endtask

   task automatic check_val(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   initial begin
      int d0, vrise;
      bit pv;

      // inputs {start,abort,clr_err,full,hot,empty}
      vt.push_back(mk("idle_rst",    6'b000001, 2'd0, 5'b00000, 3'd0, 1, 3));
      vt.push_back(mk("n_fill",      6'b100001, 2'd1, 5'b10001, 3'd0, 0, 3));
      vt.push_back(mk("n_heat",      6'b000100, 2'd1, 5'b01001, 3'd0, 0, 3));
      vt.push_back(mk("n_wash",      6'b000110, 2'd1, 5'b00101, 3'd0, 0, 3));
      vt.push_back(mk("n_drain",     6'b000110, 2'd1, 5'b00011, 3'd0, 0, 30));
      vt.push_back(mk("n_rfill",     6'b000001, 2'd1, 5'b10001, 3'd0, 0, 3));
      vt.push_back(mk("n_rinse",     6'b000100, 2'd1, 5'b00101, 3'd0, 0, 3));
      vt.push_back(mk("n_drain2",    6'b000100, 2'd1, 5'b00011, 3'd0, 0, 30));
      vt.push_back(mk("n_idle",      6'b000001, 2'd1, 5'b00000, 3'd0, 0, 3));
      vt.push_back(mk("f_fill",      6'b100001, 2'd0, 5'b10001, 3'd0, 0, 3));
      vt.push_back(mk("f_busystart", 6'b100001, 2'd0, 5'b10001, 3'd0, 1, 5));
      vt.push_back(mk("f_fill_to",   6'b000001, 2'd0, 5'b00001, 3'd1, 0, 25));
      vt.push_back(mk("f_start_ign", 6'b100001, 2'd0, 5'b00001, 3'd1, 1, 4));
      vt.push_back(mk("f_clr_wet",   6'b001000, 2'd0, 5'b00001, 3'd1, 1, 3));
      vt.push_back(mk("f_clr",       6'b001001, 2'd0, 5'b00000, 3'd0, 0, 2));
      vt.push_back(mk("a_fill",      6'b100100, 2'd0, 5'b10001, 3'd0, 0, 3));
      vt.push_back(mk("a_wash",      6'b000110, 2'd0, 5'b00101, 3'd0, 0, 5));
      vt.push_back(mk("a_abort",     6'b010110, 2'd0, 5'b00011, 3'd0, 1, 1));
      vt.push_back(mk("a_ab_hold",   6'b010110, 2'd0, 5'b00011, 3'd0, 1, 3));
      vt.push_back(mk("a_idle",      6'b000001, 2'd0, 5'b00000, 3'd0, 0, 2));
      vt.push_back(mk("w_fill",      6'b100100, 2'd2, 5'b10001, 3'd0, 0, 3));
      vt.push_back(mk("w_heat",      6'b000100, 2'd2, 5'b01001, 3'd0, 0, 3));
      vt.push_back(mk("w_lost",      6'b000000, 2'd2, 5'b00001, 3'd4, 1, 1));
      vt.push_back(mk("w_start_ign", 6'b100001, 2'd2, 5'b00001, 3'd4, 1, 4));
      vt.push_back(mk("w_clr",       6'b001001, 2'd2, 5'b00000, 3'd0, 0, 2));
      vt.push_back(mk("st_and_ab",   6'b110001, 2'd3, 5'b00000, 3'd0, 1, 4));

      model_reset();
      cycle();
      cycle();
      rst = 1'b0;

      d0 = done_seen;
      for (int i = 0; i < 9; i++) run_vec(vt[i]);
      check_val("normal_done_pulses", done_seen - d0, 1);
      d0 = done_seen;
      for (int i = 9; i < vt.size(); i++) run_vec(vt[i]);
      check_val("abort_fault_no_done", done_seen - d0, 0);

      // Sensor arriving on the timeout cycle wins.
      {start, abort, clr_err, full, hot, empty} = 6'b100001;
      rinses = 2'd0;
      cycle();
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (m_ph != M_FILL || m_el == FTO) break;
         cycle();
      end
      full = 1'b1;
      cycle();
      check_val("full_at_timeout", int'({dut_act(), err_code}), int'({5'b01001, 3'd0}));
      {abort, full, empty} = 3'b110;
      cycle();
      {abort, empty} = 2'b01;
      cycle();
      cycle();

      // Reset in RINSE, then a fresh program with no rinses.
      {start, abort, clr_err, full, hot, empty} = 6'b100110;
      rinses = 2'd2;
      for (int c = 0; c < 200; c++) begin
         if (m_ph == M_RINSE) break;
         cycle();
         start = 1'b0;
         empty = (m_ph == M_DRAIN);
      end
      check_val("reach_rinse", int'(dut_act()), int'(5'b00101));
      rst = 1'b1;
      #1;
      check_val("rst_async", int'({dut_act(), busy, done, err_code}), 0);
      cycle();
      cycle();
      rst = 1'b0;
      {start, full, hot, empty} = 4'b1110;
      rinses = 2'd0;
      d0 = done_seen; vrise = 0; pv = 0;
      for (int c = 0; c < 200; c++) begin
         if (done_seen != d0) break;
         cycle();
         start = 1'b0;
         empty = (m_ph == M_DRAIN);
         if (valve === 1'b1 && !pv) vrise++;
         pv = (valve === 1'b1);
      end
      check_val("post_rst_done", done_seen - d0, 1);
      check_val("post_rst_fills", vrise, 1);

      // Randomized sensor traffic shaped by the current program phase.
      for (int c = 0; c < 4000; c++) begin
         start   = ($urandom % 4) == 0;
         abort   = ($urandom % 150) == 0;
         clr_err = ($urandom % 4) == 0;
         rinses  = 2'($urandom);
         full    = 1'($urandom);
         hot     = 1'($urandom);
         empty   = 1'($urandom);
         case (m_ph)
            M_FILL, M_RFILL: full = ($urandom % 6) == 0;
            M_HEAT:          begin full = ($urandom % 40) != 0; hot = ($urandom % 6) == 0; end
            M_WASH, M_RINSE: full = ($urandom % 60) != 0;
            M_DRAIN, M_ABD:  empty = ($urandom % 6) == 0;
            M_FAULT:         empty = ($urandom % 3) == 0;
            default:         ;
         endcase
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
